stall_ctrl: RTL
===============

// Module: stall_ctrl
// PURPOSE
//  Central stall scheduler for the 5-stage pipeline (PC/IF/ID/EX/MEM/WB).
//  Merges ID load-use requests, EX multi-cycle mul/div occupancy and MEM data-SRAM
//  wait requests into the per-stage stall[] bus (bit=1 is `Stop), bit k = stage k.
//  Sequences the shared mul/div unit (start handshake, busy tracking, watchdog)
//  and keeps saturating per-cause stall counters for performance tuning.
// PARAMETERS
//  STALL_W     6   width of stall bus (0=PC,1=IF,2=ID,3=EX,4=MEM,5=WB)
//  MD_TIMEOUT  64  max cycles in MD_RUN before watchdog fires (>=2)
//  CNT_W       32  width of each performance counter
// PORTS
//  clk            in   1        pipeline clock, all state on posedge
//  rst            in   1        synchronous active-high reset
//  id_stallreq    in   1        ID load-use hazard (combinational from ID)
//  ex_md_start    in   1        EX holds a mul/div that must issue this cycle
//  md_ready       in   1        mul/div unit result valid (1-cycle pulse)
//  mem_stallreq   in   1        MEM waiting on data SRAM
//  perf_clr       in   1        clear all perf counters (1-cycle pulse)
//  stall          out  STALL_W  per-stage hold vector
//  md_go          out  1        start pulse to mul/div unit
//  md_busy        out  1        high while state==MD_RUN
//  md_timeout     out  1        sticky watchdog flag
//  cnt_id_stall   out  CNT_W    cycles stalled by load-use
//  cnt_md_stall   out  CNT_W    cycles stalled by mul/div
//  cnt_mem_stall  out  CNT_W    cycles stalled by MEM
// BEHAVIOUR
//  Reset: state=IDLE; wdog=0; md_timeout=0; all counters=0; stall=0, md_go=0,
//   md_busy=0 during any cycle rst=1 (outputs forced, not just next-cycle).
//  stall is combinational from state + same-cycle requests (0-cycle latency);
//   priority MEM > MD > ID, highest active cause alone selects the pattern:
//   mem_stallreq                    -> 6'b011111 (bubble into WB)
//   md_stall                        -> 6'b001111 (bubble into MEM)
//   id_stallreq                     -> 6'b000111 (bubble into EX)
//   none                            -> 6'b000000
//  md_stall = (IDLE & ex_md_start) | (MD_RUN & ~md_ready).
//  FSM (2 states):
//   IDLE  : md_go = ex_md_start & ~mem_stallreq. If md_go -> MD_RUN, wdog=0.
//           If ex_md_start & mem_stallreq: stay IDLE, retry next cycle (no go).
//   MD_RUN: md_busy=1; wdog increments each cycle. md_ready=1 -> md_stall=0
//           this cycle, -> IDLE next. wdog==MD_TIMEOUT-1 & ~md_ready ->
//           md_timeout<=1 (sticky until rst), -> IDLE, stall released this cycle.
//           md_go never asserted in MD_RUN; md_ready in IDLE is ignored.
//  md_ready and watchdog expiry in same cycle: ready wins, md_timeout unchanged.
//  Counters: each increments by 1 per cycle its cause is the selected one
//   (priority-resolved, so exactly one counter moves per stalled cycle);
//   saturate at all-ones; perf_clr zeroes all three, clear beats increment.
//  Widths: wdog is $clog2(MD_TIMEOUT) bits, compare unsigned.
//  rst mid-MD_RUN: abandons op, IDLE next cycle; unit is not notified.
// TESTING
//  1 rst=1 with all reqs high -> stall=0, md_go=0; after release all cnt=0.
//  2 id_stallreq 1 cycle -> stall=6'b000111 that cycle, cnt_id_stall=1.
//  3 ex_md_start@T, md_ready@T+5 -> md_go@T, stall=001111 T..T+4, 0 at T+5,
//    md_busy T+1..T+5, cnt_md_stall=5.
//  4 ex_md_start+mem_stallreq@T, mem clears@T+1 -> stall=011111@T, md_go@T+1.
//  5 md_go, no md_ready, MD_TIMEOUT=4 -> stall released 4th MD_RUN cycle,
//    md_timeout=1 stays set, state IDLE.
//  6 CNT_W=4, 20 load-use cycles -> cnt_id_stall=15; perf_clr -> 0.

Source files
------------

// File: rtl/stall_ctrl.sv
// Central stall scheduler: merges load-use, mul/div and MEM wait requests into
// the per-stage stall bus, sequences the shared mul/div unit and counts stall causes.
module stall_ctrl #(
  parameter int STALL_W    = 6,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_stallreq,
  input  logic               ex_md_start,
  input  logic               md_ready,
  input  logic               mem_stallreq,
  input  logic               perf_clr,
  output logic [STALL_W-1:0] stall,
  output logic               md_go,
  output logic               md_busy,
  output logic               md_timeout,
  output logic [CNT_W-1:0]   cnt_id_stall,
  output logic [CNT_W-1:0]   cnt_md_stall,
  output logic [CNT_W-1:0]   cnt_mem_stall
);

  localparam int WD_W = $clog2(MD_TIMEOUT);

  // Each pattern freezes every stage up to the one receiving the bubble.
  localparam logic [STALL_W-1:0] PAT_MEM = STALL_W'(5'b11111);
  localparam logic [STALL_W-1:0] PAT_MD  = STALL_W'(4'b1111);
  localparam logic [STALL_W-1:0] PAT_ID  = STALL_W'(3'b111);

  typedef enum logic {S_IDLE, S_MD_RUN} state_t;

  state_t           r_state;
  logic [WD_W-1:0]  r_wdog;
  logic             r_md_timeout;
  logic [CNT_W-1:0] r_cnt_id;
  logic [CNT_W-1:0] r_cnt_md;
  logic [CNT_W-1:0] r_cnt_mem;

  logic w_idle;
  logic w_run;
  logic w_wd_expire;
  logic w_md_stall;
  logic w_go;
  logic w_sel_mem;
  logic w_sel_md;
  logic w_sel_id;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_idle      = (r_state == S_IDLE);
  assign w_run       = (r_state == S_MD_RUN);
  // A same-cycle md_ready always beats the watchdog.
  assign w_wd_expire = w_run & (r_wdog == WD_W'(MD_TIMEOUT - 1)) & ~md_ready;
  assign w_md_stall  = (w_idle & ex_md_start) | (w_run & ~md_ready & ~w_wd_expire);
  assign w_go        = w_idle & ex_md_start & ~mem_stallreq;

  assign w_sel_mem = mem_stallreq;
  assign w_sel_md  = ~mem_stallreq & w_md_stall;
  assign w_sel_id  = ~mem_stallreq & ~w_md_stall & id_stallreq;

  always_comb begin
    stall   = '0;
    md_go   = 1'b0;
    md_busy = 1'b0;
    if (!rst) begin
      md_go   = w_go;
      md_busy = w_run;
      if (w_sel_mem)     stall = PAT_MEM;
      else if (w_sel_md) stall = PAT_MD;
      else if (w_sel_id) stall = PAT_ID;
    end
  end

  assign md_timeout    = r_md_timeout;
  assign cnt_id_stall  = r_cnt_id;
  assign cnt_md_stall  = r_cnt_md;
  assign cnt_mem_stall = r_cnt_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wdog       <= '0;
      r_md_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state <= S_MD_RUN;
            r_wdog  <= '0;
          end
        end
        S_MD_RUN: begin
          r_wdog <= r_wdog + WD_W'(1);
          if (md_ready) begin
            r_state <= S_IDLE;
          end else if (w_wd_expire) begin
            r_md_timeout <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      r_cnt_id  <= '0;
      r_cnt_md  <= '0;
      r_cnt_mem <= '0;
    end else begin
      if (w_sel_id)  r_cnt_id  <= sat_inc(r_cnt_id);
      if (w_sel_md)  r_cnt_md  <= sat_inc(r_cnt_md);
      if (w_sel_mem) r_cnt_mem <= sat_inc(r_cnt_mem);
    end
  end

endmodule
